// File: rtl/stream_merge_pkg.sv
// Shared constants for the two-to-one stream merger.
// Source and mode encodings match the companion 1-to-2 demux.
package stream_merge_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;

    localparam logic SRC_X = 1'b1;
    localparam logic SRC_Y = 1'b0;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with fixed-select override.
// last_grant only moves when the granted word is actually taken.
import stream_merge_pkg::*;

module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_x,
    input  logic req_y,
    input  logic mode,
    input  logic sel,
    input  logic advance,
    output logic grant,
    output logic grant_vld
);

    logic last_grant;
    logic rr;

    assign rr = (mode == MODE_RR);

    always_comb begin
        grant     = SRC_Y;
        grant_vld = 1'b0;
        unique case (1'b1)
            !rr: begin
                grant     = sel;
                grant_vld = 1'b1;
            end
            rr && req_x && req_y: begin
                grant     = ~last_grant;
                grant_vld = 1'b1;
            end
            rr && req_x && !req_y: begin
                grant     = SRC_X;
                grant_vld = 1'b1;
            end
            rr && !req_x && req_y: begin
                grant     = SRC_Y;
                grant_vld = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_Y;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/stream_merge2.sv
// Merges sources x and y onto one registered, source-tagged channel
// with saturating per-source accepted-word counters.
import stream_merge_pkg::*;

module stream_merge2 #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_in,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] y_in,
    input  logic              y_valid,
    output logic              y_ready,
    input  logic              mode,
    input  logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  x_cnt,
    output logic [CNT_W-1:0]  y_cnt
);

    logic load_en;
    logic grant;
    logic grant_vld;
    logic x_acc;
    logic y_acc;
    logic acc;

    // Single output slot: refill whenever it is empty or being drained.
    assign load_en = !out_valid || out_ready;

    assign x_ready = !rst && load_en && grant_vld && (grant == SRC_X);
    assign y_ready = !rst && load_en && grant_vld && (grant == SRC_Y);

    assign x_acc = x_valid && x_ready;
    assign y_acc = y_valid && y_ready;
    assign acc   = x_acc || y_acc;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_x     (x_valid),
        .req_y     (y_valid),
        .mode      (mode),
        .sel       (sel),
        .advance   (acc),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_Y;
        end else if (load_en) begin
            out_valid <= acc;
            if (acc) begin
                out_data <= (grant == SRC_X) ? x_in : y_in;
                out_src  <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (x_acc && (x_cnt != '1)) begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (y_acc && (y_cnt != '1)) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_merge2.sv
// Randomized + directed bench for stream_merge2 against a
// transaction-level model; a narrow-counter copy checks saturation.
module tb_stream_merge2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic       x_valid = 1'b0;
    logic       y_valid = 1'b0;
    logic       mode = 1'b0;
    logic       sel = 1'b0;
    logic       out_ready = 1'b1;

    logic        x_ready, y_ready, out_src, out_valid;
    logic [9:0]  out_data;
    logic [15:0] x_cnt, y_cnt;

    logic        x_ready3, y_ready3, out_src3, out_valid3;
    logic [9:0]  out_data3;
    logic [2:0]  x_cnt3, y_cnt3;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: the word sitting in the output slot and who was last served.
    bit       m_valid = 0;
    bit [9:0] m_data = 0;
    bit       m_src = 0;
    bit       m_last = 0;
    int       m_cx = 0;
    int       m_cy = 0;

    always #5 clk = ~clk;

    stream_merge2 #(.DATA_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_cnt(x_cnt), .y_cnt(y_cnt)
    );

    stream_merge2 #(.DATA_W(10), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready3),
        .y_in(y_in), .y_valid(y_valid), .y_ready(y_ready3),
        .mode(mode), .sel(sel),
        .out_data(out_data3), .out_src(out_src3),
        .out_valid(out_valid3), .out_ready(out_ready),
        .x_cnt(x_cnt3), .y_cnt(y_cnt3)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Who may deliver a word this cycle, from the arbitration rules.
    task automatic m_offer(output bit rx, output bit ry);
        bit room, who, any;
        rx = 0;
        ry = 0;
        room = !m_valid || out_ready;
        any = 1;
        who = 0;
        if (mode) who = sel;
        else if (x_valid && y_valid) who = !m_last;
        else if (x_valid) who = 1;
        else if (y_valid) who = 0;
        else any = 0;
        if (!rst && room && any) begin
            rx = who;
            ry = !who;
        end
    endtask

    always @(posedge clk) begin
        bit rx, ry;
        m_offer(rx, ry);
        if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0;
            m_last = 0; m_cx = 0; m_cy = 0;
        end else if (!m_valid || out_ready) begin
            if (rx && x_valid) begin
                m_valid = 1; m_data = x_in; m_src = 1;
                m_last = 1; m_cx++;
            end else if (ry && y_valid) begin
                m_valid = 1; m_data = y_in; m_src = 0;
                m_last = 0; m_cy++;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit rx, ry;
        if (cmp_en) begin
            m_offer(rx, ry);
            chk("x_ready", x_ready, rx);
            chk("y_ready", y_ready, ry);
            chk("out_valid", out_valid, m_valid);
            chk("out_data", out_data, m_data);
            chk("out_src", out_src, m_src);
            chk("x_cnt", x_cnt, (m_cx > 65535) ? 65535 : m_cx);
            chk("y_cnt", y_cnt, (m_cy > 65535) ? 65535 : m_cy);
            chk("x_cnt3", x_cnt3, (m_cx > 7) ? 7 : m_cx);
            chk("y_cnt3", y_cnt3, (m_cy > 7) ? 7 : m_cy);
            chk("out_data3", out_data3, m_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both sources pushing
        rst = 1; x_valid = 1; y_valid = 1;
        mode = 0; out_ready = 1;
        step();
        cmp_en = 1;
        repeat (2) step();
        chk("rst_x_ready", x_ready, 0);
        chk("rst_y_ready", y_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_x_cnt", x_cnt, 0);

        // Round-robin contention, x served first
        x_in = 10'h155; y_in = 10'h2AA;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_src", out_src, (i % 2 == 0) ? 1 : 0);
            chk("rr_data", out_data,
                (i % 2 == 0) ? 10'h155 : 10'h2AA);
        end
        chk("rr_x_cnt", x_cnt, 4);
        chk("rr_y_cnt", y_cnt, 4);

        // Fixed select
        mode = 1; sel = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fix_x_ready", x_ready, 0);
            chk("fix_src_y", out_src, 0);
        end
        sel = 1;
        step();
        chk("fix_src_x", out_src, 1);
        chk("fix_data_x", out_data, 10'h155);

        // Backpressure
        y_valid = 0; x_in = 10'h001;
        step();
        chk("bp_load", out_data, 10'h001);
        out_ready = 0; x_in = 10'h002;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", out_data, 10'h001);
            chk("bp_valid", out_valid, 1);
            chk("bp_x_ready", x_ready, 0);
            chk("bp_y_ready", y_ready, 0);
        end
        out_ready = 1;
        step();
        chk("bp_next", out_data, 10'h002);
        chk("bp_nobubble", out_valid, 1);

        // Counter saturation on the narrow copy
        rst = 1;
        step();
        rst = 0;
        repeat (10) step();
        chk("sat_x_cnt3", x_cnt3, 7);
        chk("sat_x_cnt", x_cnt, 10);

        // Reset during a stall
        out_ready = 0;
        step();
        chk("st_valid", out_valid, 1);
        rst = 1;
        step();
        chk("st_rst_valid", out_valid, 0);
        chk("st_rst_data", out_data, 0);
        rst = 0; mode = 0; out_ready = 1;
        x_valid = 1; y_valid = 1; x_in = 10'h3FF;
        step();
        chk("st_first_x", out_src, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            x_in = 10'($urandom);
            y_in = 10'($urandom);
            x_valid = ($urandom_range(0, 3) != 0);
            y_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = ~sel;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
